// File: rtl/ex_stage_p.sv
// ex_stage_p: execute stage (forwarding, AC-in/AC-out accumulators, ALU); EX_STAGE_MUL_EN adds a shift-add multiplier FSM.
// Latency: one cycle for ALU ops; WIDTH+1 cycles acceptance-to-valid_out for MUL when EX_STAGE_MUL_EN is defined.
// Backpressure: stall is high while the multiplier iterates and upstream must hold; there is no downstream ready.
module ex_stage_p #(
  parameter int WIDTH  = 8,
  parameter int RD_W   = 2,
  parameter int CTRL_W = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic [2:0]        funct,
  input  logic [WIDTH-1:0]  reg_val,
  input  logic [WIDTH-1:0]  imm,
  input  logic [WIDTH-1:0]  pc,
  input  logic              sel_imm,
  input  logic              load_ac,
  input  logic              store_out,
  input  logic [1:0]        fwd,
  input  logic              fwd_to_ac,
  input  logic [WIDTH-1:0]  data_mem,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [RD_W-1:0]   rd_in,
  output logic              stall,
  output logic              valid_out,
  output logic [WIDTH-1:0]  ac_out,
  output logic              zero_out,
  output logic              carry_out,
  output logic [WIDTH-1:0]  jump_target,
  output logic [WIDTH-1:0]  rs_out,
  output logic [RD_W-1:0]   rd_out,
  output logic [CTRL_W-1:0] ctrl_out
);

  logic              accept;
  logic [WIDTH-1:0]  acBase;
  logic [WIDTH-1:0]  acInSrc;
  logic [WIDTH-1:0]  opA;
  logic [WIDTH-1:0]  acIn;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  aluRes;
  logic              aluCarry;
  logic              mulStart;
  logic              mulDone;
  logic              mulWrite;
  logic [WIDTH-1:0]  mulRes;
  logic [CTRL_W-1:0] mulDoneCtrl;

  assign accept = valid_in && !stall;
  assign acBase = sel_imm ? imm : reg_val;

  // The forward mux serves exactly one path; the other keeps its base value.
  always_comb begin
    acInSrc = acBase;
    opA     = reg_val;
    if (fwd_to_ac) begin
      case (fwd)
        2'b01:   acInSrc = ac_out;
        2'b10:   acInSrc = data_mem;
        default: acInSrc = acBase;
      endcase
    end else begin
      case (fwd)
        2'b01:   opA = ac_out;
        2'b10:   opA = data_mem;
        default: opA = reg_val;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acIn <= '0;
    end else if (accept && load_ac) begin
      acIn <= acInSrc;
    end
  end

  assign sum = {1'b0, opA} + {1'b0, acIn};

  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    case (funct)
      3'b000: begin
        aluRes   = sum[WIDTH-1:0];
        aluCarry = sum[WIDTH];
      end
      3'b001: begin
        aluRes   = opA - acIn;
        aluCarry = (opA < acIn);
      end
      3'b010: aluRes = opA & acIn;
      3'b011: aluRes = opA | acIn;
      3'b100: aluRes = opA ^ acIn;
      3'b101: aluRes = {{(WIDTH-1){1'b0}}, (opA < acIn)};
      3'b110: begin
        aluRes   = {opA[WIDTH-2:0], 1'b0};
        aluCarry = opA[WIDTH-1];
      end
      default: begin
        aluRes   = '0;
        aluCarry = 1'b0;
      end
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} mulState_t;
  localparam int CNT_W = $clog2(WIDTH);

  mulState_t         state;
  mulState_t         nextState;
  logic [CNT_W-1:0]  mulCnt;
  logic [WIDTH-1:0]  mulAcc;
  logic [WIDTH-1:0]  mulA;
  logic [WIDTH-1:0]  mulB;
  logic [WIDTH-1:0]  mulProd;
  logic              mulLast;
  logic              mulStore;
  logic [CTRL_W-1:0] mulCtrl;

  assign mulStart = accept && (funct == 3'b111);
  assign mulLast  = (state == MUL) && (mulCnt == CNT_W'(WIDTH - 1));
  assign mulProd  = mulAcc + (mulB[0] ? mulA : '0);
  assign stall    = (state == MUL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      MUL:     if (mulLast) nextState = DONE;
      default: nextState = mulStart ? MUL : IDLE;
    endcase
  end

  // Multiplier consumes one bit of B per cycle, low bit first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mulAcc   <= '0;
      mulA     <= '0;
      mulB     <= '0;
      mulCnt   <= '0;
      mulStore <= 1'b0;
      mulCtrl  <= '0;
    end else if (mulStart) begin
      mulAcc   <= '0;
      mulA     <= opA;
      mulB     <= acIn;
      mulCnt   <= '0;
      mulStore <= store_out && !load_ac;
      mulCtrl  <= ctrl_in;
    end else if (state == MUL) begin
      mulAcc <= mulProd;
      mulA   <= {mulA[WIDTH-2:0], 1'b0};
      mulB   <= {1'b0, mulB[WIDTH-1:1]};
      mulCnt <= mulCnt + CNT_W'(1);
    end
  end

  assign mulDone     = mulLast;
  assign mulWrite    = mulStore;
  assign mulRes      = mulProd;
  assign mulDoneCtrl = mulCtrl;
`else
  assign stall       = 1'b0;
  assign mulStart    = 1'b0;
  assign mulDone     = 1'b0;
  assign mulWrite    = 1'b0;
  assign mulRes      = '0;
  assign mulDoneCtrl = '0;
`endif

  // Bubble cycles clear valid_out and ctrl_out; the data registers hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_out   <= 1'b0;
      ac_out      <= '0;
      zero_out    <= 1'b0;
      carry_out   <= 1'b0;
      jump_target <= '0;
      rs_out      <= '0;
      rd_out      <= '0;
      ctrl_out    <= '0;
    end else begin
      valid_out <= 1'b0;
      ctrl_out  <= '0;
      if (accept) begin
        jump_target <= pc + imm;
        rs_out      <= reg_val;
        rd_out      <= rd_in;
        if (!mulStart) begin
          valid_out <= 1'b1;
          ctrl_out  <= ctrl_in;
          if (store_out && !load_ac) begin
            ac_out    <= aluRes;
            zero_out  <= (aluRes == '0);
            carry_out <= aluCarry;
          end
        end
      end
      if (mulDone) begin
        valid_out <= 1'b1;
        ctrl_out  <= mulDoneCtrl;
        if (mulWrite) begin
          ac_out    <= mulRes;
          zero_out  <= (mulRes == '0);
          carry_out <= 1'b0;
        end
      end
    end
  end

endmodule
